// File: rtl/tt_scan_ctrl.sv
// Truth-table scanner: walks all 16 input vectors of a shared 4-input function
// unit, captures its output per vector and compares against an expected table.
module tt_scan_ctrl #(
    parameter int SETTLE       = 0,
    parameter bit STOP_ON_FAIL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] exp_tt,
    output logic [3:0]  fx,
    input  logic        fy,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] tt_out,
    output logic [4:0]  mism_cnt,
    output logic [3:0]  mism_idx,
    output logic [1:0]  dbg_state
);

    // Request/completion protocol: start is a level sampled only while idle
    // (busy=0); once accepted, busy stays high until the cycle done pulses for
    // exactly one cycle. Starts seen while busy are dropped, never queued.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        FIN    = 2'd3
    } state_t;

    localparam int          SETTLE_LAST_I = (SETTLE > 0) ? SETTLE - 1 : 0;
    localparam logic [3:0]  SETTLE_LAST   = SETTLE_LAST_I[3:0];
    // Each vector starts in DRIVE only when there is settling time to spend.
    localparam state_t      VEC_ENTRY     = (SETTLE > 0) ? DRIVE : SAMPLE;

    state_t      state;
    logic [15:0] exp_q;
    logic [3:0]  settle_cnt;
    logic        mismatch;
    logic        last_vec;
    logic        stop_now;

    always_comb begin
        mismatch = (fy != exp_q[fx]);
        last_vec = (fx == 4'hF);
        stop_now = last_vec || (STOP_ON_FAIL && mismatch);
    end

    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            fx         <= 4'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            tt_out     <= 16'd0;
            mism_cnt   <= 5'd0;
            mism_idx   <= 4'd0;
            settle_cnt <= 4'd0;
            exp_q      <= 16'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        exp_q      <= exp_tt;
                        tt_out     <= 16'd0;
                        mism_cnt   <= 5'd0;
                        mism_idx   <= 4'd0;
                        pass       <= 1'b0;
                        fx         <= 4'd0;
                        settle_cnt <= 4'd0;
                        busy       <= 1'b1;
                        state      <= VEC_ENTRY;
                    end
                end

                DRIVE: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        pass  <= 1'b0;
                        state <= IDLE;
                    end else if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= 4'd0;
                        state      <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end

                SAMPLE: begin
                    // An abort here also drops this cycle's capture.
                    if (abort) begin
                        busy  <= 1'b0;
                        pass  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        tt_out[fx] <= fy;
                        if (mismatch) begin
                            if (mism_cnt != 5'd16) begin
                                mism_cnt <= mism_cnt + 5'd1;
                            end
                            if (mism_cnt == 5'd0) begin
                                mism_idx <= fx;
                            end
                        end
                        if (stop_now) begin
                            state <= FIN;
                        end else begin
                            fx         <= fx + 4'd1;
                            settle_cnt <= 4'd0;
                            state      <= VEC_ENTRY;
                        end
                    end
                end

                FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    pass  <= (mism_cnt == 5'd0);
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tt_scan_ctrl.sv
// Bench for tt_scan_ctrl: three instances (plain, stop-on-fail, slow unit with
// SETTLE=3) driven by directed and random scans against a vector-walk model.
module tb_tt_scan_ctrl;

    logic             clk;
    logic             rst;
    logic [2:0]       start_v;
    logic [2:0]       abort_v;
    logic [2:0][15:0] exp_v;
    logic [2:0][3:0]  fx_v;
    logic [2:0]       fy_v;
    logic [2:0]       busy_v;
    logic [2:0]       done_v;
    logic [2:0]       pass_v;
    logic [2:0][15:0] tt_v;
    logic [2:0][4:0]  cnt_v;
    logic [2:0][3:0]  idx_v;
    logic [2:0][1:0]  st_v;

    logic [2:0][15:0] unit_v;
    logic [3:0]       age2;
    logic [3:0]       last_fx2;

    int tests;
    int fails;

    typedef struct {
        logic [15:0] tt;
        logic [4:0]  cnt;
        logic [3:0]  idx;
        logic        pass;
        logic [3:0]  last_fx;
        int          lat;
    } res_t;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    tt_scan_ctrl #(.SETTLE(0), .STOP_ON_FAIL(1'b0)) u_plain (
        .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort_v[0]), .exp_tt(exp_v[0]),
        .fx(fx_v[0]), .fy(fy_v[0]), .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
        .tt_out(tt_v[0]), .mism_cnt(cnt_v[0]), .mism_idx(idx_v[0]), .dbg_state(st_v[0])
    );

    tt_scan_ctrl #(.SETTLE(0), .STOP_ON_FAIL(1'b1)) u_sof (
        .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort_v[1]), .exp_tt(exp_v[1]),
        .fx(fx_v[1]), .fy(fy_v[1]), .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
        .tt_out(tt_v[1]), .mism_cnt(cnt_v[1]), .mism_idx(idx_v[1]), .dbg_state(st_v[1])
    );

    tt_scan_ctrl #(.SETTLE(3), .STOP_ON_FAIL(1'b0)) u_slow (
        .clk(clk), .rst(rst), .start(start_v[2]), .abort(abort_v[2]), .exp_tt(exp_v[2]),
        .fx(fx_v[2]), .fy(fy_v[2]), .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
        .tt_out(tt_v[2]), .mism_cnt(cnt_v[2]), .mism_idx(idx_v[2]), .dbg_state(st_v[2])
    );

    // Slow unit: output is wrong until fx has been stable for 3 cycles.
    always @(negedge clk) begin
        if (fx_v[2] != last_fx2) begin
            age2     <= 4'd0;
            last_fx2 <= fx_v[2];
        end else if (age2 != 4'hF) begin
            age2 <= age2 + 4'd1;
        end
    end

    always_comb begin
        fy_v[0] = unit_v[0][fx_v[0]];
        fy_v[1] = unit_v[1][fx_v[1]];
        fy_v[2] = (age2 >= 4'd3) ? unit_v[2][fx_v[2]] : ~unit_v[2][fx_v[2]];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Walk vectors 0..15 in order; a vector takes settle+1 cycles, plus one
    // finishing cycle before done.
    function automatic res_t ref_scan(input logic [15:0] unit, input logic [15:0] expt,
                                      input bit sof, input int settle);
        res_t r;
        int   n;
        r.tt = 16'd0; r.cnt = 5'd0; r.idx = 4'd0; n = 0;
        for (int i = 0; i < 16; i++) begin
            n = i + 1;
            r.tt[i] = unit[i];
            if (unit[i] != expt[i]) begin
                if (r.cnt == 5'd0) r.idx = i[3:0];
                r.cnt = r.cnt + 5'd1;
                if (sof) break;
            end
        end
        r.pass    = (r.cnt == 5'd0);
        r.last_fx = 4'(n - 1);
        r.lat     = n * (settle + 1) + 1;
        return r;
    endfunction

    task automatic run_scan(input int k, input logic [15:0] unit, input logic [15:0] expt,
                            input string tag, input bit poke_start, input bit abort_fin);
        res_t m;
        int   cyc;
        m = ref_scan(unit, expt, (k == 1), (k == 2) ? 3 : 0);
        unit_v[k] = unit;
        exp_v[k]  = expt;
        @(posedge clk); #1;
        start_v[k] = 1'b1;
        @(posedge clk); #1;
        start_v[k] = 1'b0;
        check({tag, ".busy_on"}, 32'(busy_v[k]), 32'd1);
        cyc = 0;
        while (cyc < 200) begin
            if (poke_start && cyc == 8) start_v[k] = 1'b1;
            if (poke_start && cyc == 9) start_v[k] = 1'b0;
            if (abort_fin && cyc == m.lat - 1) abort_v[k] = 1'b1;
            @(posedge clk); #1;
            cyc++;
            if (done_v[k]) break;
        end
        abort_v[k] = 1'b0;
        start_v[k] = 1'b0;
        check({tag, ".latency"}, 32'(cyc), 32'(m.lat));
        check({tag, ".tt_out"}, 32'(tt_v[k]), 32'(m.tt));
        check({tag, ".mism_cnt"}, 32'(cnt_v[k]), 32'(m.cnt));
        check({tag, ".mism_idx"}, 32'(idx_v[k]), 32'(m.idx));
        check({tag, ".pass"}, 32'(pass_v[k]), 32'(m.pass));
        check({tag, ".busy_off"}, 32'(busy_v[k]), 32'd0);
        check({tag, ".fx_hold"}, 32'(fx_v[k]), 32'(m.last_fx));
        @(posedge clk); #1;
        check({tag, ".done_pulse"}, 32'(done_v[k]), 32'd0);
        if (poke_start) begin
            repeat (3) @(posedge clk);
            #1;
            check({tag, ".no_queued"}, 32'(busy_v[k]), 32'd0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int k = 0; k < 3; k++) begin
            check({tag, ".fx"}, 32'(fx_v[k]), 32'd0);
            check({tag, ".busy"}, 32'(busy_v[k]), 32'd0);
            check({tag, ".done"}, 32'(done_v[k]), 32'd0);
            check({tag, ".pass"}, 32'(pass_v[k]), 32'd0);
            check({tag, ".tt_out"}, 32'(tt_v[k]), 32'd0);
            check({tag, ".mism_cnt"}, 32'(cnt_v[k]), 32'd0);
            check({tag, ".mism_idx"}, 32'(idx_v[k]), 32'd0);
        end
    endtask

    initial begin
        int          cyc;
        int          done_seen;
        int          busy_seen;
        int          k;
        logic [15:0] u;
        logic [15:0] mask;

        tests = 0; fails = 0;
        rst = 1'b0; start_v = '0; abort_v = '0; exp_v = '0;
        unit_v = {3{16'h1686}};

        #1 rst = 1'b1;
        #2;
        check_all_zero("reset");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Class-1686 unit, matching / one-off / fully inverted expectations.
        run_scan(0, 16'h1686, 16'h1686, "match", 1'b0, 1'b0);
        run_scan(0, 16'h1686, 16'h1687, "one_off", 1'b0, 1'b0);
        run_scan(0, 16'h1686, 16'hE979, "all_bad", 1'b0, 1'b0);

        run_scan(1, 16'h1686, 16'h168E, "sof_stop", 1'b0, 1'b0);
        run_scan(1, 16'h1686, 16'h1686, "sof_clean", 1'b0, 1'b0);

        run_scan(2, 16'h1686, 16'h1686, "slow", 1'b1, 1'b0);

        run_scan(0, 16'hA5C3, 16'hA5C3, "abort_in_fin", 1'b0, 1'b1);

        // Abort while vector 5 is being sampled; mismatches at 2 and 5.
        unit_v[0] = 16'h1686;
        exp_v[0]  = 16'h1686 ^ 16'h0024;
        @(posedge clk); #1;
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        cyc = 0;
        while (cyc < 40 && fx_v[0] != 4'd5) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("abort.reach_v5", 32'(fx_v[0]), 32'd5);
        abort_v[0] = 1'b1;
        @(posedge clk); #1;
        abort_v[0] = 1'b0;
        check("abort.busy", 32'(busy_v[0]), 32'd0);
        check("abort.pass", 32'(pass_v[0]), 32'd0);
        check("abort.tt_out", 32'(tt_v[0]), 32'(16'h1686 & 16'h001F));
        check("abort.mism_cnt", 32'(cnt_v[0]), 32'd1);
        check("abort.mism_idx", 32'(idx_v[0]), 32'd2);
        done_seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done_v[0]) done_seen++;
        end
        check("abort.no_done", 32'(done_seen), 32'd0);

        // start and abort together while idle: no scan begins.
        start_v[0] = 1'b1; abort_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0; abort_v[0] = 1'b0;
        busy_seen = 0;
        repeat (5) begin
            if (busy_v[0]) busy_seen++;
            @(posedge clk); #1;
        end
        check("start_abort.busy", 32'(busy_seen), 32'd0);
        check("start_abort.tt_kept", 32'(tt_v[0]), 32'(16'h1686 & 16'h001F));

        // Reset asserted mid-scan away from a clock edge.
        exp_v[0] = 16'h1686;
        @(posedge clk); #1;
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        repeat (7) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_all_zero("mid_rst");
        @(posedge clk); #2;
        rst = 1'b0;
        done_seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done_v[0]) done_seen++;
        end
        check("mid_rst.no_done", 32'(done_seen), 32'd0);
        run_scan(0, 16'h1686, 16'h1687, "after_rst", 1'b0, 1'b0);

        // Random units and expectations across all three instances.
        for (int it = 0; it < 12; it++) begin
            k = it % 3;
            u = 16'($urandom);
            case (it % 4)
                0:       mask = 16'd0;
                1:       mask = 16'd1 << $urandom_range(0, 15);
                default: mask = 16'($urandom);
            endcase
            run_scan(k, u, u ^ mask, "rand", 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
